// File: rtl/pulse_stretch_mc_if.sv
// Handshake bundle for pulse_stretch_mc: event strobes and overflow clear in,
// stretched pulses, busy and sticky overflow flags out.
interface pulse_stretch_mc_if #(
  parameter int unsigned CH = 4
) ();
  logic [CH-1:0] pulse_in;
  logic          clr_ovf;
  logic [CH-1:0] pulse_out;
  logic [CH-1:0] busy;
  logic [CH-1:0] overflow;

  modport master (
    output pulse_in,
    output clr_ovf,
    input  pulse_out,
    input  busy,
    input  overflow
  );

  modport slave (
    input  pulse_in,
    input  clr_ovf,
    output pulse_out,
    output busy,
    output overflow
  );
endinterface

// File: rtl/pulse_stretch_mc.sv
// Multi-channel pulse stretcher for fast-to-slow single-bit crossings. Queue mode
// replays every event as its own pulse; merge mode retriggers the running pulse.
module pulse_stretch_mc #(
  parameter int unsigned CH      = 4,
  parameter int unsigned STRETCH = 3,
  parameter int unsigned GAP     = 2,
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned MODE    = 0
) (
  input  logic                clk,
  input  logic                rst,
  pulse_stretch_mc_if.slave   bus
);

  localparam int unsigned CNT_MAX = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned PW      = $clog2(QDEPTH + 1);
  localparam bit          MERGE   = (MODE != 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]    r_state    [CH];
  logic [CW-1:0] r_cnt      [CH];
  logic [PW-1:0] r_pend     [CH];
  logic [1:0]    w_nxt_state[CH];
  logic [CW-1:0] w_nxt_cnt  [CH];
  logic [PW-1:0] w_nxt_pend [CH];
  logic [CH-1:0] w_ovf_set;
  logic [CH-1:0] r_pulse_out;
  logic [CH-1:0] r_busy;
  logic [CH-1:0] r_overflow;

  // Per-channel next-state, counter and pending-queue logic
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      w_nxt_state[i] = r_state[i];
      w_nxt_cnt[i]   = r_cnt[i];
      w_nxt_pend[i]  = r_pend[i];
      w_ovf_set[i]   = 1'b0;
      case (r_state[i])
        ST_IDLE: begin
          if (bus.pulse_in[i]) begin
            w_nxt_state[i] = ST_HIGH;
            w_nxt_cnt[i]   = CW'(STRETCH);
          end
        end
        ST_HIGH: begin
          if (MERGE && bus.pulse_in[i]) begin
            w_nxt_cnt[i] = CW'(STRETCH);
          end else if (r_cnt[i] <= CW'(1)) begin
            w_nxt_state[i] = ST_GAP;
            w_nxt_cnt[i]   = CW'(GAP);
          end else begin
            w_nxt_cnt[i] = r_cnt[i] - CW'(1);
          end
          if (!MERGE && bus.pulse_in[i]) begin
            if (r_pend[i] < PW'(QDEPTH)) w_nxt_pend[i] = r_pend[i] + PW'(1);
            else                         w_ovf_set[i]  = 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt[i] <= CW'(1)) begin
            // An event arriving in the final gap cycle is consumed by the pulse
            // starting now, so a dequeue and an enqueue cancel without loss.
            if ((r_pend[i] != '0) || bus.pulse_in[i]) begin
              w_nxt_state[i] = ST_HIGH;
              w_nxt_cnt[i]   = CW'(STRETCH);
              if ((r_pend[i] != '0) && (MERGE || !bus.pulse_in[i]))
                w_nxt_pend[i] = r_pend[i] - PW'(1);
            end else begin
              w_nxt_state[i] = ST_IDLE;
              w_nxt_cnt[i]   = '0;
            end
          end else begin
            w_nxt_cnt[i] = r_cnt[i] - CW'(1);
            if (bus.pulse_in[i]) begin
              if (MERGE)                        w_nxt_pend[i] = PW'(1);
              else if (r_pend[i] < PW'(QDEPTH)) w_nxt_pend[i] = r_pend[i] + PW'(1);
              else                              w_ovf_set[i]  = 1'b1;
            end
          end
        end
        default: begin
          w_nxt_state[i] = ST_IDLE;
          w_nxt_cnt[i]   = '0;
          w_nxt_pend[i]  = '0;
        end
      endcase
    end
  end

  // State registers; outputs are registered copies of the next-state decode
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
        r_pend[i]  <= '0;
      end
      r_pulse_out <= '0;
      r_busy      <= '0;
      r_overflow  <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        r_state[i]     <= w_nxt_state[i];
        r_cnt[i]       <= w_nxt_cnt[i];
        r_pend[i]      <= w_nxt_pend[i];
        r_pulse_out[i] <= (w_nxt_state[i] == ST_HIGH);
        r_busy[i]      <= (w_nxt_state[i] != ST_IDLE) || (w_nxt_pend[i] != '0);
      end
      r_overflow <= (r_overflow & ~{CH{bus.clr_ovf}}) | w_ovf_set;
    end
  end

  assign bus.pulse_out = r_pulse_out;
  assign bus.busy      = r_busy;
  assign bus.overflow  = r_overflow;

endmodule
